// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: issues word reads and buffers responses in a DEPTH-entry queue for decode.
// Latency: a bus completion in cycle N is visible at the queue head in cycle N+1 (no bypass).
// Backpressure: no new request while halted or full; an issued request holds until the bus completes.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        ireq_ren,
  output logic [31:0] ireq_addr,
  input  logic        ireq_busy,
  input  logic [31:0] ireq_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   pending_pc;
  logic [31:0]   pending_pc_next;
  logic          req_held;

  // Queue storage, pointers and occupancy
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic          q_fault [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  // Per-cycle control decisions
  logic          complete;
  logic          pop;
  logic          flush;
  logic          push;
  logic          push_ok;
  logic [31:0]   push_instr;
  logic [31:0]   push_pc;
  logic          push_fault;
  logic          apply;
  logic [31:0]   apply_pc;

  // The current fetch address is always presented; while a request is
  // outstanding (including DRAIN) fetch_pc is frozen, which keeps addr stable.
  assign ireq_addr   = fetch_pc;
  assign complete    = ireq_ren & ~ireq_busy;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign push_ok     = push & (flush | (count != DEPTH_C) | pop);

  // Head outputs read as zero when the queue is empty
  always_comb begin
    instr       = '0;
    instr_pc    = '0;
    instr_fault = 1'b0;
    if (instr_valid) begin
      instr       = q_instr[head];
      instr_pc    = q_pc[head];
      instr_fault = q_fault[head];
    end
  end

  // Request generation: a started request stays up until the bus takes it
  always_comb begin
    ireq_ren = 1'b0;
    case (state)
      FETCH:   ireq_ren = req_held | (~halt & (count < DEPTH_C));
      DRAIN:   ireq_ren = 1'b1;
      default: ireq_ren = 1'b0;
    endcase
    if (RST) begin
      ireq_ren = 1'b0;
    end
  end

  // Next-state and queue-event decode; redirect outranks everything else
  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    pending_pc_next = pending_pc;
    flush           = 1'b0;
    push            = 1'b0;
    push_instr      = '0;
    push_pc         = '0;
    push_fault      = 1'b0;
    apply           = 1'b0;
    apply_pc        = '0;

    if (redirect) begin
      flush = 1'b1;
      if (ireq_ren & ireq_busy) begin
        // Cannot withdraw an accepted request: wait it out, remember the target
        state_next      = DRAIN;
        pending_pc_next = redirect_pc;
      end else begin
        apply    = 1'b1;
        apply_pc = redirect_pc;
      end
    end else if ((state == DRAIN) && complete) begin
      // Stale response is dropped; restart at the remembered target
      flush    = 1'b1;
      apply    = 1'b1;
      apply_pc = pending_pc;
    end else if ((state == FETCH) && complete) begin
      push          = 1'b1;
      push_instr    = ireq_rdata;
      push_pc       = fetch_pc;
      fetch_pc_next = fetch_pc + 32'd4;
    end

    if (apply) begin
      fetch_pc_next = apply_pc;
      if (apply_pc[1:0] != 2'b00) begin
        // Misaligned target: hand decode a single fault marker and park
        state_next = FAULT;
        push       = 1'b1;
        push_instr = '0;
        push_pc    = apply_pc;
        push_fault = 1'b1;
      end else begin
        state_next = FETCH;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Fetch address, redirect target and outstanding-request tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      req_held   <= 1'b0;
    end else begin
      fetch_pc   <= fetch_pc_next;
      pending_pc <= pending_pc_next;
      req_held   <= ireq_ren & ireq_busy;
    end
  end

  // Circular queue update; a flush empties it before any same-cycle push
  always_ff @(posedge CLK) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      if (push) begin
        q_instr[0] <= push_instr;
        q_pc[0]    <= push_pc;
        q_fault[0] <= push_fault;
        tail       <= PW'(1);
        count      <= CW'(1);
      end else begin
        tail  <= '0;
        count <= '0;
      end
    end else begin
      if (push_ok) begin
        q_instr[tail] <= push_instr;
        q_pc[tail]    <= push_pc;
        q_fault[tail] <= push_fault;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
